gather_credit_returner: RTL

Destination-side partner of the gather credit counter at an FC start port. It sits at each FC destination node's ejection port and tracks payload (BODY) flits of gather packets entering the local gather buffer and leaving it. As buffer slots drain, it returns them to the source as batched credit updates on `credit_upd`. Updates are batched by threshold, by timeout, or flushed at end of packet. Over a packet it returns exactly FCpl-2 credits, matching the source's per-head debit.

---
 rtl/gather_credit_returner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gather_credit_returner.sv
// gather_credit_returner: destination-side credit return for FC gather packets.
// Tracks payload flits entering and draining from the local gather buffer and
// hands drained slots back to the source as batched credit updates (threshold,
// timeout, or end-of-packet flush).
module gather_credit_returner #(
  parameter int unsigned isFD          = 0,
  parameter int unsigned FCpl          = 16,
  parameter int unsigned CREDIT_THRESH = 4,
  parameter int unsigned TIMEOUT       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic [1:0]  flit_type,
  input  logic        drain,
  output logic [31:0] credit_upd,
  output logic [31:0] pending,
  output logic        err
);

  localparam int unsigned CW = 32;

  // Flit type encoding shared with the ejection port
  localparam logic [1:0] FLIT_HEAD = 2'd1;
  localparam logic [1:0] FLIT_BODY = 2'd2;
  localparam logic [1:0] FLIT_TAIL = 2'd3;

  localparam logic [CW-1:0] PAYLOAD = CW'(FCpl - 2);
  localparam logic [CW-1:0] THRESH  = CW'(CREDIT_THRESH);
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT - 1);
  localparam bit            ACTIVE  = (isFD != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] buf_cnt, buf_cnt_nxt;
  logic [CW-1:0] bcnt, bcnt_nxt;
  logic [CW-1:0] pend, pend_nxt;
  logic [CW-1:0] timer, timer_nxt;
  logic [CW-1:0] credit_nxt;
  logic          err_nxt;

  logic          is_head, is_body, is_tail;
  logic          head_ok, body_ok, tail_ok, drain_ok;
  logic          emit;
  logic [CW-1:0] pend_sum;

  // Event validation, counter updates, emit decision and next state
  always_comb begin
    state_nxt   = state;
    buf_cnt_nxt = buf_cnt;
    bcnt_nxt    = bcnt;
    pend_nxt    = pend;
    timer_nxt   = timer;
    credit_nxt  = '0;
    err_nxt     = 1'b0;
    emit        = 1'b0;
    pend_sum    = pend;

    is_head  = fire && (flit_type == FLIT_HEAD);
    is_body  = fire && (flit_type == FLIT_BODY);
    is_tail  = fire && (flit_type == FLIT_TAIL);

    // Illegal events are flagged and excluded from every count
    drain_ok = drain && (buf_cnt != '0);
    body_ok  = is_body && (state == COLLECT) && (bcnt < PAYLOAD);
    head_ok  = is_head && (state != COLLECT);
    tail_ok  = is_tail && (state == COLLECT);
    err_nxt  = (drain && !drain_ok) || (is_body && !body_ok) ||
               (is_head && !head_ok) || (is_tail && !tail_ok);

    buf_cnt_nxt = buf_cnt + CW'(body_ok) - CW'(drain_ok);

    if (head_ok) begin
      bcnt_nxt = '0;
    end else if (body_ok) begin
      bcnt_nxt = bcnt + CW'(1);
    end

    pend_sum = pend + CW'(drain_ok);

    // Flush at end of buffer drain, or when a new head overtakes the drain
    emit = (pend_sum != '0) &&
           ((pend_sum >= THRESH) ||
            (timer == TMAX) ||
            (((state == DRAIN) || tail_ok) && (buf_cnt_nxt == '0)) ||
            (head_ok && (state == DRAIN)));

    if (emit) begin
      credit_nxt = pend_sum;
      pend_nxt   = '0;
      timer_nxt  = '0;
    end else begin
      pend_nxt = pend_sum;
      if (pend == '0) begin
        timer_nxt = '0;
      end else if (timer != TMAX) begin
        timer_nxt = timer + CW'(1);
      end
    end

    unique case (state)
      IDLE: begin
        if (head_ok) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (tail_ok) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (head_ok) begin
          state_nxt = COLLECT;
        end else if ((buf_cnt_nxt == '0) && (pend_nxt == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers; an inert node stays in reset
  always_ff @(posedge clk) begin
    if (rst || !ACTIVE) begin
      state      <= IDLE;
      buf_cnt    <= '0;
      bcnt       <= '0;
      pend       <= '0;
      timer      <= '0;
      credit_upd <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      buf_cnt    <= buf_cnt_nxt;
      bcnt       <= bcnt_nxt;
      pend       <= pend_nxt;
      timer      <= timer_nxt;
      credit_upd <= credit_nxt;
      err        <= err_nxt;
    end
  end

  assign pending = pend;

endmodule
